// File: rtl/hnf_link_rxreq_wrap_pkg.sv
// Shared REQ flit layout, link opcodes, credit-FSM encodings and depth default
// for the HN-F RXREQ link receiver.
package hnf_link_rxreq_wrap_pkg;

  // Field layout
  localparam int CHIE_REQ_FLIT_WIDTH        = 128;
  localparam int CHIE_REQ_FLIT_QOS_LSB      = 0;
  localparam int CHIE_REQ_FLIT_QOS_WIDTH    = 4;
  localparam int CHIE_REQ_FLIT_TGTID_LSB    = 4;
  localparam int CHIE_REQ_FLIT_TGTID_WIDTH  = 11;
  localparam int CHIE_REQ_FLIT_SRCID_LSB    = 15;
  localparam int CHIE_REQ_FLIT_SRCID_WIDTH  = 11;
  localparam int CHIE_REQ_FLIT_TXNID_LSB    = 26;
  localparam int CHIE_REQ_FLIT_TXNID_WIDTH  = 12;
  localparam int CHIE_REQ_FLIT_OPCODE_LSB   = 38;
  localparam int CHIE_REQ_FLIT_OPCODE_WIDTH = 7;
  localparam int CHIE_REQ_FLIT_ADDR_LSB     = 45;
  localparam int CHIE_REQ_FLIT_ADDR_WIDTH   = 52;

  // Link-level opcodes and credit FSM encodings
  localparam logic [CHIE_REQ_FLIT_OPCODE_WIDTH-1:0] REQLCRDRETURN = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } rxreq_st_e;

  // Depth default
  localparam int RXREQ_BUF_DEPTH_DEF = 4;

  typedef struct packed {
    logic [CHIE_REQ_FLIT_ADDR_WIDTH-1:0]   addr;
    logic [CHIE_REQ_FLIT_OPCODE_WIDTH-1:0] opcode;
    logic [CHIE_REQ_FLIT_TXNID_WIDTH-1:0]  txnid;
    logic [CHIE_REQ_FLIT_SRCID_WIDTH-1:0]  srcid;
    logic [CHIE_REQ_FLIT_QOS_WIDTH-1:0]    qos;
  } req_fields_t;

  function automatic req_fields_t req_decode(input logic [CHIE_REQ_FLIT_WIDTH-1:0] f);
    req_fields_t r;
    r.addr   = f[CHIE_REQ_FLIT_ADDR_LSB   +: CHIE_REQ_FLIT_ADDR_WIDTH];
    r.opcode = f[CHIE_REQ_FLIT_OPCODE_LSB +: CHIE_REQ_FLIT_OPCODE_WIDTH];
    r.txnid  = f[CHIE_REQ_FLIT_TXNID_LSB  +: CHIE_REQ_FLIT_TXNID_WIDTH];
    r.srcid  = f[CHIE_REQ_FLIT_SRCID_LSB  +: CHIE_REQ_FLIT_SRCID_WIDTH];
    r.qos    = f[CHIE_REQ_FLIT_QOS_LSB    +: CHIE_REQ_FLIT_QOS_WIDTH];
    return r;
  endfunction

endpackage

// File: rtl/hnf_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head data and an occupancy count.
module hnf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        do_wr, do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_rd)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

endmodule

// File: rtl/hnf_link_rxreq_wrap.sv
// CHI-E RXREQ link receiver: registers incoming flits, absorbs LCrdReturn,
// buffers requests for the consumer and runs L-credit issue / drain.
module hnf_link_rxreq_wrap
  import hnf_link_rxreq_wrap_pkg::*;
#(
  parameter int RXREQ_BUF_DEPTH = RXREQ_BUF_DEPTH_DEF,
  parameter int RXREQ_CNT_WIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  rxreqflitpend,
  input  logic                                  rxreqflitv,
  input  logic [CHIE_REQ_FLIT_WIDTH-1:0]        rxreqflit,
  output logic                                  rxreq_lcrdv,
  input  logic                                  rxreq_link_en,
  output logic                                  rxreq_link_idle,
  output logic                                  rxreq_valid,
  input  logic                                  rxreq_ready,
  output logic [CHIE_REQ_FLIT_WIDTH-1:0]        rxreq_flit,
  output logic [CHIE_REQ_FLIT_OPCODE_WIDTH-1:0] rxreq_opcode,
  output logic [CHIE_REQ_FLIT_TXNID_WIDTH-1:0]  rxreq_txnid,
  output logic [CHIE_REQ_FLIT_SRCID_WIDTH-1:0]  rxreq_srcid,
  output logic [CHIE_REQ_FLIT_ADDR_WIDTH-1:0]   rxreq_addr,
  output logic [CHIE_REQ_FLIT_QOS_WIDTH-1:0]    rxreq_qos,
  output logic                                  rxreq_crd_err
);
  localparam int CW = RXREQ_CNT_WIDTH + 1;

  rxreq_st_e                      st;
  logic                           in_v_q;
  logic [CHIE_REQ_FLIT_WIDTH-1:0] in_flit_q;
  logic [RXREQ_CNT_WIDTH-1:0]     crd_out_q, fifo_count;
  logic                           fifo_full, fifo_empty;
  logic                           is_ret, no_crd, consume, fifo_wr, drop_full, issue_ok;
  logic [CW-1:0]                  crd_sum, crd_nxt;
  req_fields_t                    head_f;
  logic                           unused_pend;

  assign unused_pend = rxreqflitpend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_v_q    <= 1'b0;
      in_flit_q <= '0;
    end else begin
      in_v_q    <= rxreqflitv;
      in_flit_q <= rxreqflit;
    end
  end

  // A flit with no credit outstanding is dropped and consumes nothing.
  assign is_ret    = (in_flit_q[CHIE_REQ_FLIT_OPCODE_LSB +: CHIE_REQ_FLIT_OPCODE_WIDTH] == REQLCRDRETURN);
  assign no_crd    = in_v_q && (crd_out_q == '0);
  assign consume   = in_v_q && !no_crd;
  assign fifo_wr   = consume && !is_ret && !fifo_full;
  assign drop_full = consume && !is_ret && fifo_full;

  // Pops in this cycle are deliberately not counted; the space is credited next cycle.
  assign crd_sum  = CW'(crd_out_q) + CW'(fifo_count) + CW'(in_v_q) + CW'(rxreq_lcrdv);
  assign issue_ok = (st == ST_RUN) && (crd_sum < CW'(RXREQ_BUF_DEPTH));
  assign crd_nxt  = CW'(crd_out_q) + CW'(rxreq_lcrdv) - CW'(consume);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crd_out_q     <= '0;
      rxreq_crd_err <= 1'b0;
    end else begin
      crd_out_q <= crd_nxt[RXREQ_CNT_WIDTH-1:0];
      if (no_crd || drop_full) rxreq_crd_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= ST_IDLE;
      rxreq_lcrdv     <= 1'b0;
      rxreq_link_idle <= 1'b1;
    end else begin
      rxreq_lcrdv <= issue_ok;
      case (st)
        ST_IDLE: if (rxreq_link_en) begin
          st              <= ST_RUN;
          rxreq_link_idle <= 1'b0;
        end
        ST_RUN: if (!rxreq_link_en) st <= ST_DRAIN;
        ST_DRAIN: begin
          if (rxreq_link_en) st <= ST_RUN;
          else if (crd_out_q == '0 && !rxreq_lcrdv && !in_v_q) begin
            st              <= ST_IDLE;
            rxreq_link_idle <= 1'b1;
          end
        end
        default: begin
          st              <= ST_IDLE;
          rxreq_link_idle <= 1'b1;
        end
      endcase
    end
  end

  hnf_sync_fifo #(
    .WIDTH (CHIE_REQ_FLIT_WIDTH),
    .DEPTH (RXREQ_BUF_DEPTH),
    .CNT_W (RXREQ_CNT_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (in_flit_q),
    .rd_en   (rxreq_ready),
    .rd_data (rxreq_flit),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rxreq_valid  = !fifo_empty;
  assign head_f       = req_decode(rxreq_flit);
  assign rxreq_opcode = head_f.opcode;
  assign rxreq_txnid  = head_f.txnid;
  assign rxreq_srcid  = head_f.srcid;
  assign rxreq_addr   = head_f.addr;
  assign rxreq_qos    = head_f.qos;

endmodule

// File: doc/hnf_link_rxreq_wrap.md
Name: hnf_link_rxreq_wrap

Overview:
- Receive side of a CHI-E REQ channel link. Accepts REQ flits from the link layer under L-credit flow control and buffers them in a small FIFO.
- Presents each buffered flit, with pre-decoded fields, to the downstream request consumer (HN-F RX pipeline or SN-F front end) over a valid/ready handshake.
- Owns L-credit issue, LCrdReturn absorption, and the credit-drain sequence for link deactivation.

Parameters:
- RXREQ_BUF_DEPTH, 4, FIFO entries and maximum L-credits outstanding (2..15).
- RXREQ_CNT_WIDTH, 4, counter width; must be at least clog2(RXREQ_BUF_DEPTH+1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- rxreqflitpend  in  1  flit-pending hint; ignored.
- rxreqflitv  in  1  flit valid from link.
- rxreqflit  in  CHIE_REQ_FLIT_WIDTH  REQ flit.
- rxreq_lcrdv  out  1  L-credit grant to the transmitter; one credit per cycle high.
- rxreq_link_en  in  1  1 = issue credits; 0 = request deactivation.
- rxreq_link_idle  out  1  deactivated and all credits returned.
- rxreq_valid  out  1  head flit available.
- rxreq_ready  in  1  consumer accepts head.
- rxreq_flit  out  CHIE_REQ_FLIT_WIDTH  head flit, whole.
- rxreq_opcode / rxreq_txnid / rxreq_srcid / rxreq_addr / rxreq_qos  out  CHIE_REQ_FLIT_*_WIDTH  fields sliced from the head flit.
- rxreq_crd_err  out  1  sticky protocol error: flit received with no credit outstanding.

Behaviour:
- Reset values:
  - All outputs 0, except rxreq_link_idle = 1.
  - All counters 0; FIFO empty; FSM in IDLE.
- Input stage: rxreqflitv and rxreqflit are registered (in_v_q, in_flit_q) every cycle; no enable.
- Credit return: a registered flit with opcode REQLCRDRETURN (0x00) is a returned credit. It is never written to the FIFO; it only decrements crd_out_q.
- Data path: any other registered flit is written to the FIFO and decrements crd_out_q.
- Latency: flit on the link in cycle N → rxreq_valid high in cycle N+2, assuming the FIFO was empty.
- Pop: the FIFO pops when rxreq_valid && rxreq_ready. Output fields are combinational slices of the head entry and are held stable while valid && !ready.
- crd_out_q: credits granted and not yet consumed.
  - Next value = crd_out_q + issue − consume, where consume = in_v_q.
  - Simultaneous issue and consume leaves it unchanged.
- Issue condition: rxreq_lcrdv (registered) is set for the next cycle when all of the following hold:
  - FSM is RUN;
  - crd_out_q + fifo_count + in_v_q + rxreq_lcrdv < RXREQ_BUF_DEPTH.
  - Pop in the same cycle is not credited; this is conservative and frees a credit next cycle.
- FSM states:
  - IDLE: no credits issued; link_idle = 1. Goes to RUN when rxreq_link_en = 1.
  - RUN: issues credits per the rule above. Goes to DRAIN when rxreq_link_en = 0.
  - DRAIN: no credits issued; waits for crd_out_q == 0 with no credit in flight (rxreq_lcrdv = 0 and in_v_q = 0), then goes to IDLE. If rxreq_link_en returns to 1 in DRAIN, go back to RUN.
  - FIFO contents drain independently of FSM state; link_idle does not require an empty FIFO.
- Error conditions:
  - in_v_q = 1 with crd_out_q == 0: set rxreq_crd_err (sticky until reset), drop the flit, leave crd_out_q at 0 (saturate, no underflow).
  - A non-return flit arriving with the FIFO full cannot occur when credits are correct. If it does, set rxreq_crd_err and drop the flit.
- Reset mid-traffic: everything clears asynchronously, including flits in flight and credits outstanding. The link partner must also be reset.
- Width rule: every counter compare is done at RXREQ_CNT_WIDTH+1 bits, so sums never wrap.

Decomposition:
- Shared definitions:
  - Field ranges and widths come from chie_defines.v.
  - REQLCRDRETURN opcode and the FSM state encodings (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10) go in hnf_defines.v.
  - The depth default goes in hnf_param.v.
- Sub-module: one synchronous FIFO, hnf_sync_fifo. It is parameterised by width and depth, exposes count, full and empty, and gives first-word-fall-through head data.
- Credit FSM and counters stay in the wrapper.

Test Plan:
- Reset then link_en=1, no flits, ready=1 → exactly 4 lcrdv pulses on consecutive cycles, then lcrdv stays 0; crd_out_q=4.
- Send 4 flits (txnid 0x01..0x04) with ready=0 → rxreq_valid rises 2 cycles after the first flit; no new credits; release ready → txnids pop in order 0x01..0x04, and 4 new credits are issued as space frees.
- Back-to-back streaming, one flit per cycle, ready=1 → sustained throughput after the initial credit fill; crd_out_q + fifo_count never exceeds 4.
- link_en=0 with 3 credits out, then 3 LCrdReturn flits (opcode 0x00) → no FIFO writes, rxreq_valid stays 0; link_idle=1 on the cycle after the last return is registered.
- Drive rxreqflitv=1 while crd_out_q=0 → rxreq_crd_err=1 and remains 1; the flit is not presented; crd_out_q stays 0.
- Assert rst_n=0 mid-stream with 2 entries buffered → asynchronously rxreq_valid=0, rxreq_lcrdv=0, link_idle=1, rxreq_crd_err=0.
